// File: rtl/frac_clken_gen_if.sv
// Rate-configuration handshake for frac_clken_gen.
// The requester drives valid/ch/inc. The generator returns ready and a one-cycle error pulse.
interface frac_clken_gen_if #(
   parameter int NUM_CH = 2,
   parameter int ACC_W  = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_inc,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_inc,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel phase-accumulator clock-enable generator; ce_out is registered, one cycle after the crossing edge.
// Backpressure: cfg_ready is low while settling after reset or reprogram, so requests wait until RUN.
module frac_clken_gen #(
   parameter int                        NUM_CH      = 2,
   parameter int                        ACC_W       = 32,
   parameter int                        REF_HZ      = 50000000,
   parameter logic [NUM_CH*ACC_W-1:0]   DEF_INC     = {32'd3579545, 32'd49999999},
   parameter int                        LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst,
   frac_clken_gen_if.slave   cfg,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);
   localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [ACC_W-1:0] MOD      = ACC_W'(REF_HZ);

   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("frac_clken_gen: NUM_CH must be in 1..8");
   end
   if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("frac_clken_gen: LOCK_CYCLES must be >= 1");
   end
   if (ACC_W < 62 && (longint'(REF_HZ) * 2) >= (longint'(1) << ACC_W)) begin : g_bad_acc_w
      $error("frac_clken_gen: ACC_W too narrow for REF_HZ");
   end
   for (genvar g = 0; g < NUM_CH; g++) begin : g_def_chk
      if (DEF_INC[g*ACC_W +: ACC_W] >= MOD) begin : g_bad_def
         $error("frac_clken_gen: DEF_INC entry must be below REF_HZ");
      end
   end

   typedef enum logic {SETTLE, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc [NUM_CH];
   logic [ACC_W-1:0]   inc [NUM_CH];
   logic [ACC_W-1:0]   sum [NUM_CH];
   logic [NUM_CH-1:0]  wrap;
   logic               cfg_fire;
   logic               cfg_bad;

   // inc < MOD and 2*MOD fits in ACC_W, so the add never overflows
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i]  = acc[i] + inc[i];
         wrap[i] = (sum[i] >= MOD);
      end
   end

   assign cfg_fire = cfg.cfg_valid & cfg.cfg_ready;
   assign cfg_bad  = (cfg.cfg_inc >= MOD) || (32'(cfg.cfg_ch) >= NUM_CH);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state         <= SETTLE;
         cnt           <= CNT_LOAD;
         ce_out        <= '0;
         locked        <= 1'b0;
         cfg.cfg_ready <= 1'b0;
         cfg.cfg_err   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            inc[i] <= DEF_INC[i*ACC_W +: ACC_W];
         end
      end else begin
         cfg.cfg_err <= 1'b0;
         case (state)
            SETTLE: begin
               ce_out <= '0;
               for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
               if (cnt == '0) begin
                  state         <= RUN;
                  locked        <= 1'b1;
                  cfg.cfg_ready <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RUN: begin
               if (cfg_fire && !cfg_bad) begin
                  // Reprogram realigns every channel, so a crossing on this edge is dropped
                  for (int i = 0; i < NUM_CH; i++) begin
                     acc[i] <= '0;
                     if (32'(cfg.cfg_ch) == i) inc[i] <= cfg.cfg_inc;
                  end
                  ce_out        <= '0;
                  locked        <= 1'b0;
                  cfg.cfg_ready <= 1'b0;
                  cnt           <= CNT_LOAD;
                  state         <= SETTLE;
               end else begin
                  cfg.cfg_err <= cfg_fire;
                  for (int i = 0; i < NUM_CH; i++) begin
                     acc[i]    <= wrap[i] ? (sum[i] - MOD) : sum[i];
                     ce_out[i] <= wrap[i];
                  end
               end
            end
            default: state <= SETTLE;
         endcase
      end
   end
endmodule
